// File: rtl/axil_regfile.sv
// axil_regfile: AXI4-Lite slave exposing REG_COUNT DATA_WIDTH-bit registers.
// AW and W are captured independently into holding registers; the write
// commits once both are held and the B channel can accept a response.
// Reads are single-cycle registered with one-per-cycle throughput.
// Optional feature: define AXIL_REGFILE_SLVERR_EN to answer out-of-range
// accesses with SLVERR instead of OKAY.
module axil_regfile #(
    parameter  int DATA_WIDTH = 32,
    parameter  int ADDR_WIDTH = 8,
    parameter  int REG_COUNT  = 16,
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [ADDR_WIDTH-1:0]           s_axil_awaddr,
    input  logic [2:0]                      s_axil_awprot,
    input  logic                            s_axil_awvalid,
    output logic                            s_axil_awready,
    input  logic [DATA_WIDTH-1:0]           s_axil_wdata,
    input  logic [STRB_WIDTH-1:0]           s_axil_wstrb,
    input  logic                            s_axil_wvalid,
    output logic                            s_axil_wready,
    output logic [1:0]                      s_axil_bresp,
    output logic                            s_axil_bvalid,
    input  logic                            s_axil_bready,
    input  logic [ADDR_WIDTH-1:0]           s_axil_araddr,
    input  logic [2:0]                      s_axil_arprot,
    input  logic                            s_axil_arvalid,
    output logic                            s_axil_arready,
    output logic [DATA_WIDTH-1:0]           s_axil_rdata,
    output logic [1:0]                      s_axil_rresp,
    output logic                            s_axil_rvalid,
    input  logic                            s_axil_rready,
    output logic [REG_COUNT*DATA_WIDTH-1:0] reg_q
);

    localparam int ADDR_LSB = $clog2(STRB_WIDTH);

`ifdef AXIL_REGFILE_SLVERR_EN
    localparam logic [1:0] ERR_RESP = 2'b10;
`else
    localparam logic [1:0] ERR_RESP = 2'b00;
`endif

    logic                            run_q;
    logic                            aw_held_q;
    logic                            w_held_q;
    logic [ADDR_WIDTH-1:0]           aw_addr_q;
    logic [DATA_WIDTH-1:0]           w_data_q;
    logic [STRB_WIDTH-1:0]           w_strb_q;
    logic                            bvalid_q;
    logic [1:0]                      bresp_q;
    logic                            rvalid_q;
    logic [1:0]                      rresp_q;
    logic [DATA_WIDTH-1:0]           rdata_q;
    logic [REG_COUNT*DATA_WIDTH-1:0] regs_q;
    logic [REG_COUNT*DATA_WIDTH-1:0] regs_d;

    logic                  aw_hs;
    logic                  w_hs;
    logic                  ar_hs;
    logic                  wr_fire;
    logic [31:0]           wr_idx;
    logic [31:0]           rd_idx;
    logic                  wr_in_range;
    logic                  rd_in_range;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [1:0]            wr_resp;
    logic [1:0]            rd_resp;
    logic                  unused_prot;

    assign unused_prot = ^{s_axil_awprot, s_axil_arprot};

    assign s_axil_awready = run_q && !aw_held_q;
    assign s_axil_wready  = run_q && !w_held_q;
    assign s_axil_arready = run_q && (!rvalid_q || s_axil_rready);

    assign aw_hs   = s_axil_awvalid && s_axil_awready;
    assign w_hs    = s_axil_wvalid && s_axil_wready;
    assign ar_hs   = s_axil_arvalid && s_axil_arready;
    assign wr_fire = aw_held_q && w_held_q && (!bvalid_q || s_axil_bready);

    assign wr_idx      = 32'(aw_addr_q >> ADDR_LSB);
    assign rd_idx      = 32'(s_axil_araddr >> ADDR_LSB);
    assign wr_in_range = wr_idx < 32'(REG_COUNT);
    assign rd_in_range = rd_idx < 32'(REG_COUNT);
    assign wr_resp     = wr_in_range ? 2'b00 : ERR_RESP;
    assign rd_resp     = rd_in_range ? 2'b00 : ERR_RESP;

    assign s_axil_bvalid = bvalid_q;
    assign s_axil_bresp  = bresp_q;
    assign s_axil_rvalid = rvalid_q;
    assign s_axil_rresp  = rresp_q;
    assign s_axil_rdata  = rdata_q;
    assign reg_q         = regs_q;

    // Next register contents: byte-masked merge of the held write when it fires in range.
    always_comb begin
        regs_d = regs_q;
        if (wr_fire && wr_in_range) begin
            for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
                if (w_strb_q[b]) begin
                    regs_d[wr_idx*DATA_WIDTH + b*8 +: 8] = w_data_q[b*8 +: 8];
                end
            end
        end
    end

    // Read lookup from pre-edge register state, so a same-edge write returns old data.
    always_comb begin
        rd_data = '0;
        if (rd_in_range) begin
            rd_data = regs_q[rd_idx*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Channel state, holding registers and register file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q     <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            rvalid_q  <= 1'b0;
            rresp_q   <= '0;
            rdata_q   <= '0;
            regs_q    <= '0;
        end else begin
            run_q  <= 1'b1;
            regs_q <= regs_d;

            if (wr_fire) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
                bvalid_q  <= 1'b1;
                bresp_q   <= wr_resp;
            end else if (bvalid_q && s_axil_bready) begin
                bvalid_q <= 1'b0;
            end

            // A handshake can only occur while the flag is clear, so it never races wr_fire.
            if (aw_hs) begin
                aw_held_q <= 1'b1;
                aw_addr_q <= s_axil_awaddr;
            end
            if (w_hs) begin
                w_held_q <= 1'b1;
                w_data_q <= s_axil_wdata;
                w_strb_q <= s_axil_wstrb;
            end

            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_data;
                rresp_q  <= rd_resp;
            end else if (rvalid_q && s_axil_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axil_regfile.sv
// Directed bench for axil_regfile (DATA_WIDTH=32, ADDR_WIDTH=8, REG_COUNT=16).
// Honours AXIL_REGFILE_SLVERR_EN for the expected out-of-range response.
module tb_axil_regfile;

`ifdef AXIL_REGFILE_SLVERR_EN
    localparam logic [1:0] EXP_ERR = 2'b10;
`else
    localparam logic [1:0] EXP_ERR = 2'b00;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   awaddr;
    logic [2:0]   awprot;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [7:0]   araddr;
    logic [2:0]   arprot;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready;
    logic [511:0] regs;

    logic [31:0] exp_regs [16];
    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    axil_regfile #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(8),
        .REG_COUNT (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axil_awaddr (awaddr),
        .s_axil_awprot (awprot),
        .s_axil_awvalid(awvalid),
        .s_axil_awready(awready),
        .s_axil_wdata  (wdata),
        .s_axil_wstrb  (wstrb),
        .s_axil_wvalid (wvalid),
        .s_axil_wready (wready),
        .s_axil_bresp  (bresp),
        .s_axil_bvalid (bvalid),
        .s_axil_bready (bready),
        .s_axil_araddr (araddr),
        .s_axil_arprot (arprot),
        .s_axil_arvalid(arvalid),
        .s_axil_arready(arready),
        .s_axil_rdata  (rdata),
        .s_axil_rresp  (rresp),
        .s_axil_rvalid (rvalid),
        .s_axil_rready (rready),
        .reg_q         (regs)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("%s_w%0d", tag, i), 64'(regs[i*32 +: 32]), 64'(exp_regs[i]));
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) exp_regs[i] = '0;
        rst = 1'b1;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;

        // Reset state
        repeat (2) tick();
        check("rst_awready", 64'(awready), 64'd0);
        check("rst_wready", 64'(wready), 64'd0);
        check("rst_arready", 64'(arready), 64'd0);
        check("rst_bvalid", 64'(bvalid), 64'd0);
        check("rst_rvalid", 64'(rvalid), 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        check_all_regs("rst");

        // Readies stay low until the first edge after release
        rst = 1'b0;
        check("norun_awready", 64'(awready), 64'd0);
        check("norun_arready", 64'(arready), 64'd0);
        tick();
        check("run_awready", 64'(awready), 64'd1);
        check("run_wready", 64'(wready), 64'd1);
        check("run_arready", 64'(arready), 64'd1);

        // AW and W in the same cycle
        awaddr = 8'h04; awvalid = 1'b1; wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check("same_bvalid_c1", 64'(bvalid), 64'd0);
        check("same_awready_held", 64'(awready), 64'd0);
        tick();
        exp_regs[1] = 32'hDEADBEEF;
        check("same_bvalid_c2", 64'(bvalid), 64'd1);
        check("same_bresp", 64'(bresp), 64'd0);
        check("same_reg1", 64'(regs[32 +: 32]), 64'(exp_regs[1]));
        tick();
        check("same_bclear", 64'(bvalid), 64'd0);

        // Preload register 2
        awaddr = 8'h08; awvalid = 1'b1; wdata = 32'hAAAAAAAA; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        check("pre_reg2", 64'(regs[64 +: 32]), 64'hAAAAAAAA);
        tick();

        // W three cycles ahead of AW, partial strobe
        wdata = 32'h11223344; wstrb = 4'h3; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        check("wfirst_wready_held", 64'(wready), 64'd0);
        check("wfirst_bvalid", 64'(bvalid), 64'd0);
        tick();
        tick();
        awaddr = 8'h08; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("wfirst_bvalid_c1", 64'(bvalid), 64'd0);
        tick();
        exp_regs[2] = 32'hAAAA3344;
        check("wfirst_bvalid_c2", 64'(bvalid), 64'd1);
        check("wfirst_reg2", 64'(regs[64 +: 32]), 64'(exp_regs[2]));
        tick();

        // B back-pressure with a second write pending
        bready = 1'b0;
        awaddr = 8'h0C; awvalid = 1'b1; wdata = 32'h00000001; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        exp_regs[3] = 32'h00000001;
        check("bp_bvalid_first", 64'(bvalid), 64'd1);
        awaddr = 8'h10; awvalid = 1'b1; wdata = 32'h00000055; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bp_hold_bvalid_%0d", i), 64'(bvalid), 64'd1);
            check($sformatf("bp_hold_bresp_%0d", i), 64'(bresp), 64'd0);
            check($sformatf("bp_hold_reg4_%0d", i), 64'(regs[128 +: 32]), 64'd0);
            tick();
        end
        bready = 1'b1;
        tick();
        exp_regs[4] = 32'h00000055;
        check("bp_second_bvalid", 64'(bvalid), 64'd1);
        check("bp_reg4", 64'(regs[128 +: 32]), 64'(exp_regs[4]));
        check("bp_reg3", 64'(regs[96 +: 32]), 64'(exp_regs[3]));
        tick();
        check("bp_bclear", 64'(bvalid), 64'd0);

        // Back-to-back reads; first read collides with a write to register 0
        awaddr = 8'h00; awvalid = 1'b1; wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 8'h00; arvalid = 1'b1;
        tick();
        exp_regs[0] = 32'hCAFEF00D;
        check("rd0_rvalid", 64'(rvalid), 64'd1);
        check("rd0_old_data", 64'(rdata), 64'd0);
        check("rd0_rresp", 64'(rresp), 64'd0);
        check("rd0_reg0_new", 64'(regs[0 +: 32]), 64'(exp_regs[0]));
        araddr = 8'h04;
        tick();
        arvalid = 1'b0;
        check("rd1_rvalid", 64'(rvalid), 64'd1);
        check("rd1_rdata", 64'(rdata), 64'hDEADBEEF);
        tick();
        check("rd_rclear", 64'(rvalid), 64'd0);

        // R back-pressure
        rready = 1'b0;
        araddr = 8'h08; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        check("rbp_rvalid", 64'(rvalid), 64'd1);
        check("rbp_rdata", 64'(rdata), 64'hAAAA3344);
        check("rbp_arready", 64'(arready), 64'd0);
        tick();
        check("rbp_rvalid_hold", 64'(rvalid), 64'd1);
        check("rbp_rdata_hold", 64'(rdata), 64'hAAAA3344);
        rready = 1'b1;
        tick();
        check("rbp_rclear", 64'(rvalid), 64'd0);

        // Out-of-range write and read at 0x40
        awaddr = 8'h40; awvalid = 1'b1; wdata = 32'hFFFFFFFF; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        check("oor_bvalid", 64'(bvalid), 64'd1);
        check("oor_bresp", 64'(bresp), 64'(EXP_ERR));
        check_all_regs("oor");
        tick();
        araddr = 8'h40; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        check("oor_rvalid", 64'(rvalid), 64'd1);
        check("oor_rresp", 64'(rresp), 64'(EXP_ERR));
        check("oor_rdata", 64'(rdata), 64'd0);
        tick();

        // Reset mid-cycle with AW held and R pending
        awaddr = 8'h14; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        rready = 1'b0;
        araddr = 8'h04; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        check("mr_rvalid_pre", 64'(rvalid), 64'd1);
        #3 rst = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) exp_regs[i] = '0;
        check("mr_rvalid", 64'(rvalid), 64'd0);
        check("mr_rdata", 64'(rdata), 64'd0);
        check("mr_bvalid", 64'(bvalid), 64'd0);
        check("mr_awready", 64'(awready), 64'd0);
        check("mr_arready", 64'(arready), 64'd0);
        check_all_regs("mr");
        #2 rst = 1'b0;
        #1;
        check("mr_rel_awready", 64'(awready), 64'd0);
        check("mr_rel_wready", 64'(wready), 64'd0);
        tick();
        rready = 1'b1;
        check("mr_run_awready", 64'(awready), 64'd1);
        check("mr_run_wready", 64'(wready), 64'd1);
        wdata = 32'h00000077; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        check("mr_w_held", 64'(wready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("mr_no_b_%0d", i), 64'(bvalid), 64'd0);
            check($sformatf("mr_no_r_%0d", i), 64'(rvalid), 64'd0);
        end
        check("mr_reg5", 64'(regs[160 +: 32]), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
